snake_head_move: RTL

SNAKE_HEAD_MOVE -- requirements
Module: snake_head_move

---
 rtl/snake_head_move.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/snake_head_move.sv
// ---------------------------------------------------------------------------
// snake_head_move
// Moves the snake's head one grid cell every TICK_DIV clock cycles. The head
// follows the requested direction, but a request to turn straight back on
// itself is ignored. Reaching a wall stops the game in CRASH until iStart.
//
// Ports
//   iClk        : clock, all logic on the rising edge
//   iRst        : asynchronous, active-high reset
//   iDirection  : requested direction (0=TOP, 1=DOWN, 2=LEFT, 3=RIGHT)
//   iStart      : start / restart request (pulse or level)
//   oHeadX      : head column, 0 is the left edge
//   oHeadY      : head row, 0 is the top edge
//   oHeading    : committed heading, same encoding as iDirection
//   oStep       : one-cycle pulse after each completed move
//   oCrash      : high while in CRASH
//   oRunning    : high while in RUN
// ---------------------------------------------------------------------------
module snake_head_move #(
  parameter int GRID_W   = 40,
  parameter int GRID_H   = 30,
  parameter int TICK_DIV = 12500000,
  parameter int START_X  = 20,
  parameter int START_Y  = 15
) (
  input  logic                      iClk,
  input  logic                      iRst,
  input  logic [1:0]                iDirection,
  input  logic                      iStart,
  output logic [$clog2(GRID_W)-1:0] oHeadX,
  output logic [$clog2(GRID_H)-1:0] oHeadY,
  output logic [1:0]                oHeading,
  output logic                      oStep,
  output logic                      oCrash,
  output logic                      oRunning
);

  localparam int X_W = $clog2(GRID_W);
  localparam int Y_W = $clog2(GRID_H);
  localparam int T_W = $clog2(TICK_DIV);

  localparam logic [1:0] TOP_DIR   = 2'd0;
  localparam logic [1:0] DOWN_DIR  = 2'd1;
  localparam logic [1:0] LEFT_DIR  = 2'd2;
  localparam logic [1:0] RIGHT_DIR = 2'd3;

  localparam logic [X_W-1:0] X_START = X_W'(START_X);
  localparam logic [Y_W-1:0] Y_START = Y_W'(START_Y);
  localparam logic [X_W-1:0] X_LAST  = X_W'(GRID_W - 1);
  localparam logic [Y_W-1:0] Y_LAST  = Y_W'(GRID_H - 1);
  localparam logic [T_W-1:0] T_LAST  = T_W'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    CRASH = 2'd2
  } state_t;

  state_t         state_r;
  logic [T_W-1:0] tick_r;
  logic [X_W-1:0] head_x_r;
  logic [Y_W-1:0] head_y_r;
  logic [1:0]     heading_r;
  logic           step_r;
  logic           crash_r;
  logic           running_r;

  logic           move_s;
  logic [1:0]     cand_dir_s;
  logic [X_W-1:0] next_x_s;
  logic [Y_W-1:0] next_y_s;
  logic           hit_s;

  assign oHeadX   = head_x_r;
  assign oHeadY   = head_y_r;
  assign oHeading = heading_r;
  assign oStep    = step_r;
  assign oCrash   = crash_r;
  assign oRunning = running_r;

  assign move_s = (state_r == RUN) && (tick_r == T_LAST);

  // Candidate heading: the encoding pairs opposites so that flipping bit 0
  // gives the reverse direction (TOP<->DOWN, LEFT<->RIGHT).
  always_comb begin
    cand_dir_s = iDirection;
    if (iDirection == (heading_r ^ 2'b01)) begin
      cand_dir_s = heading_r;
    end else begin
      cand_dir_s = iDirection;
    end
  end

  // Next head position for the candidate heading, flagging a wall hit instead
  // of wrapping when the head already sits on the edge it is moving towards.
  always_comb begin
    next_x_s = head_x_r;
    next_y_s = head_y_r;
    hit_s    = 1'b0;
    case (cand_dir_s)
      TOP_DIR: begin
        if (head_y_r == {Y_W{1'b0}}) begin
          hit_s = 1'b1;
        end else begin
          next_y_s = head_y_r - Y_W'(1);
        end
      end
      DOWN_DIR: begin
        if (head_y_r == Y_LAST) begin
          hit_s = 1'b1;
        end else begin
          next_y_s = head_y_r + Y_W'(1);
        end
      end
      LEFT_DIR: begin
        if (head_x_r == {X_W{1'b0}}) begin
          hit_s = 1'b1;
        end else begin
          next_x_s = head_x_r - X_W'(1);
        end
      end
      RIGHT_DIR: begin
        if (head_x_r == X_LAST) begin
          hit_s = 1'b1;
        end else begin
          next_x_s = head_x_r + X_W'(1);
        end
      end
      default: begin
        hit_s = 1'b0;
      end
    endcase
  end

  // Game FSM, move tick counter and all registered outputs.
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      state_r   <= IDLE;
      tick_r    <= {T_W{1'b0}};
      head_x_r  <= X_START;
      head_y_r  <= Y_START;
      heading_r <= TOP_DIR;
      step_r    <= 1'b0;
      crash_r   <= 1'b0;
      running_r <= 1'b0;
    end else begin
      step_r <= 1'b0;
      case (state_r)
        IDLE, CRASH: begin
          tick_r <= {T_W{1'b0}};
          if (iStart) begin
            state_r   <= RUN;
            head_x_r  <= X_START;
            head_y_r  <= Y_START;
            heading_r <= TOP_DIR;
            crash_r   <= 1'b0;
            running_r <= 1'b1;
          end else begin
            state_r <= state_r;
          end
        end
        RUN: begin
          // iStart has no effect here, including on the wall-hit cycle.
          if (move_s) begin
            tick_r    <= {T_W{1'b0}};
            heading_r <= cand_dir_s;
            if (hit_s) begin
              state_r   <= CRASH;
              crash_r   <= 1'b1;
              running_r <= 1'b0;
            end else begin
              head_x_r <= next_x_s;
              head_y_r <= next_y_s;
              step_r   <= 1'b1;
            end
          end else begin
            tick_r <= tick_r + T_W'(1);
          end
        end
        default: begin
          state_r   <= IDLE;
          tick_r    <= {T_W{1'b0}};
          crash_r   <= 1'b0;
          running_r <= 1'b0;
        end
      endcase
    end
  end

endmodule
